// File: rtl/ins_mem_arbiter.sv
// Instruction-RAM arbiter: round-robin core fetches, absolute-priority program loader.
// Optional build macro INS_ARB_WAIT_CNT_EN adds the max_wait starvation monitor output.
module ins_mem_arbiter #(
    parameter int N_CORES    = 4,
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic [N_CORES-1:0]            core_req,
    input  logic [N_CORES*ADDR_WIDTH-1:0] core_addr,
    output logic [N_CORES-1:0]            core_gnt,
    output logic [N_CORES-1:0]            core_rvalid,
    output logic [WIDTH-1:0]              core_rdata,
    input  logic                          ld_req,
    input  logic [ADDR_WIDTH-1:0]         ld_addr,
    input  logic [WIDTH-1:0]              ld_data,
    output logic                          ld_gnt,
    output logic                          ld_busy,
    output logic                          ram_wrEn,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [WIDTH-1:0]              ram_dataIn,
    input  logic [WIDTH-1:0]              ram_dataOut
`ifdef INS_ARB_WAIT_CNT_EN
    ,
    output logic [15:0]                   max_wait
`endif
);

    localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam logic [PTR_W-1:0] LAST_CORE = PTR_W'(N_CORES - 1);
    localparam logic [N_CORES-1:0] ONE_HOT0 = {{(N_CORES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_CORES-1:0] core_rvalid_q;
    logic               ld_busy_q;
    logic               win_valid_s;
    logic [PTR_W-1:0]   win_idx_s;
    logic [PTR_W-1:0]   win_next_s;

    // Round-robin search: first requesting core at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned cand_v;
        win_valid_s = 1'b0;
        win_idx_s   = '0;
        cand_v      = 0;
        for (int i = 0; i < N_CORES; i++) begin
            cand_v = int'(rr_ptr_q) + i;
            if (cand_v >= N_CORES) begin
                cand_v = cand_v - N_CORES;
            end else begin
                cand_v = cand_v;
            end
            if (!win_valid_s && core_req[cand_v]) begin
                win_valid_s = 1'b1;
                win_idx_s   = cand_v[PTR_W-1:0];
            end else begin
                win_valid_s = win_valid_s;
            end
        end
        if (win_idx_s == LAST_CORE) begin
            win_next_s = '0;
        end else begin
            win_next_s = win_idx_s + PTR_W'(1);
        end
    end

    // FSM next state plus the combinational grant and RAM port mux.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        core_gnt   = '0;
        ld_gnt     = 1'b0;
        ram_wrEn   = 1'b0;
        ram_addr   = '0;
        ram_dataIn = '0;
        if (rstN) begin
            case (state_q)
                ST_RUN: begin
                    if (ld_req) begin
                        state_d = ST_LOAD;
                    end else if (win_valid_s) begin
                        core_gnt = ONE_HOT0 << win_idx_s;
                        ram_addr = core_addr[win_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
                        rr_ptr_d = win_next_s;
                    end else begin
                        rr_ptr_d = rr_ptr_q;
                    end
                end
                ST_LOAD: begin
                    if (ld_req) begin
                        ld_gnt     = 1'b1;
                        ram_wrEn   = 1'b1;
                        ram_addr   = ld_addr;
                        ram_dataIn = ld_data;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                // Idle cycle so no fetch races the final loader write.
                ST_DRAIN: begin
                    if (ld_req) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end else begin
            state_d = ST_RUN;
        end
    end

    // State, pointer and read-valid pipeline registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q       <= ST_RUN;
            rr_ptr_q      <= '0;
            core_rvalid_q <= '0;
            ld_busy_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            core_rvalid_q <= core_gnt;
            ld_busy_q     <= (state_d != ST_RUN);
        end
    end

    assign core_rvalid = core_rvalid_q;
    assign ld_busy     = ld_busy_q;
    assign core_rdata  = ram_dataOut;

`ifdef INS_ARB_WAIT_CNT_EN
    logic [15:0] wait_cnt_q [N_CORES];
    logic [15:0] wait_cnt_d [N_CORES];
    logic [15:0] max_wait_q, max_wait_d;

    // Saturating per-core wait counters; the running maximum tracks the worst run seen.
    always_comb begin
        max_wait_d = max_wait_q;
        for (int i = 0; i < N_CORES; i++) begin
            if (core_req[i] && !core_gnt[i]) begin
                if (wait_cnt_q[i] == 16'hFFFF) begin
                    wait_cnt_d[i] = 16'hFFFF;
                end else begin
                    wait_cnt_d[i] = wait_cnt_q[i] + 16'd1;
                end
            end else begin
                wait_cnt_d[i] = 16'd0;
            end
            if (wait_cnt_d[i] > max_wait_d) begin
                max_wait_d = wait_cnt_d[i];
            end else begin
                max_wait_d = max_wait_d;
            end
        end
    end

    // Wait-counter and maximum registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < N_CORES; i++) begin
                wait_cnt_q[i] <= 16'd0;
            end
            max_wait_q <= 16'd0;
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
            max_wait_q <= max_wait_d;
        end
    end

    assign max_wait = max_wait_q;
`endif

endmodule

// File: tb/tb_ins_mem_arbiter.sv
// Directed self-checking bench for ins_mem_arbiter with a behavioural registered-read RAM.
module tb_ins_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstN;
    logic [3:0]  core_req;
    logic [31:0] core_addr;
    logic [3:0]  core_gnt;
    logic [3:0]  core_rvalid;
    logic [7:0]  core_rdata;
    logic        ld_req;
    logic [7:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        ld_gnt;
    logic        ld_busy;
    logic        ram_wrEn;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_dataIn;
    logic [7:0]  ram_dataOut;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [0:255];
    logic [7:0] raddr_q = 8'd0;

    ins_mem_arbiter dut (
        .clk(clk), .rstN(rstN),
        .core_req(core_req), .core_addr(core_addr),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_gnt(ld_gnt), .ld_busy(ld_busy),
        .ram_wrEn(ram_wrEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
        .ram_dataOut(ram_dataOut)
    );

    always #5 clk = ~clk;

    // Single-port RAM: 1-cycle write, registered read address.
    always @(posedge clk) begin
        if (ram_wrEn) mem[ram_addr] <= ram_dataIn;
        raddr_q <= ram_addr;
    end
    assign ram_dataOut = mem[raddr_q];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int i, input logic [7:0] a);
        core_addr[i*8 +: 8] = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[5]   = 8'hA3;
        rstN     = 1'b0;
        core_req = 4'hF;
        for (int i = 0; i < 4; i++) set_addr(i, 8'h20 + 8'(i));
        ld_req   = 1'b0;
        ld_addr  = 8'd0;
        ld_data  = 8'd0;

        // Reset state with every core requesting
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check_eq("rst_gnt",    32'(core_gnt),    32'h0);
        check_eq("rst_rvalid", 32'(core_rvalid), 32'h0);
        check_eq("rst_busy",   32'(ld_busy),     32'h0);
        check_eq("rst_wren",   32'(ram_wrEn),    32'h0);
        check_eq("rst_addr",   32'(ram_addr),    32'h0);
        rstN = 1'b1; #1;

        // Round robin: 0,1,2,3,0,1,2,3 with rvalid one cycle behind
        for (int k = 0; k < 8; k++) begin
            check_eq("rr_gnt",  32'(core_gnt), 32'(1) << (k % 4));
            check_eq("rr_addr", 32'(ram_addr), 32'h20 + 32'(k % 4));
            @(posedge clk); #1;
            check_eq("rr_rvalid", 32'(core_rvalid), 32'(1) << (k % 4));
            check_eq("rr_rdata",  32'(core_rdata),  32'((8'h20 + 8'(k % 4)) ^ 8'h5A));
            @(negedge clk); #1;
        end

        // Single core fetch
        core_req = 4'b0010;
        set_addr(1, 8'h05); #1;
        check_eq("single_gnt",  32'(core_gnt), 32'h2);
        check_eq("single_addr", 32'(ram_addr), 32'h05);
        check_eq("single_wren", 32'(ram_wrEn), 32'h0);
        @(posedge clk); #1;
        check_eq("single_rvalid", 32'(core_rvalid), 32'h2);
        check_eq("single_rdata",  32'(core_rdata),  32'hA3);
        @(negedge clk); #1;

        // No requests: address ignored, outputs zero
        core_req = 4'b0000;
        set_addr(1, 8'h77); #1;
        check_eq("idle_gnt",  32'(core_gnt), 32'h0);
        check_eq("idle_addr", 32'(ram_addr), 32'h0);
        @(posedge clk); #1;
        check_eq("idle_rvalid", 32'(core_rvalid), 32'h0);
        @(negedge clk); #1;

        // Pointer is at 2: search picks core3, then wraps to core0
        core_req = 4'b1001; #1;
        check_eq("wrap_gnt3", 32'(core_gnt), 32'h8);
        @(posedge clk); #1;
        check_eq("wrap_rvalid3", 32'(core_rvalid), 32'h8);
        @(negedge clk); #1;
        check_eq("wrap_gnt0", 32'(core_gnt), 32'h1);
        @(posedge clk); #1;
        check_eq("wrap_rdata0", 32'(core_rdata), 32'h20 ^ 32'h5A);
        @(negedge clk); #1;

        // Loader preempts all cores; pointer now 1
        core_req = 4'b1111;
        set_addr(1, 8'd11);
        ld_req  = 1'b1;
        ld_addr = 8'd10;
        ld_data = 8'h11; #1;
        check_eq("pre_gnt",   32'(core_gnt), 32'h0);
        check_eq("pre_ldgnt", 32'(ld_gnt),   32'h0);
        check_eq("pre_wren",  32'(ram_wrEn), 32'h0);
        @(posedge clk); #1;
        check_eq("load_busy",   32'(ld_busy),     32'h1);
        check_eq("load_rvalid", 32'(core_rvalid), 32'h0);
        @(negedge clk); #1;
        for (int j = 0; j < 3; j++) begin
            check_eq("ld_gnt",    32'(ld_gnt),     32'h1);
            check_eq("ld_wren",   32'(ram_wrEn),   32'h1);
            check_eq("ld_addr",   32'(ram_addr),   32'd10 + 32'(j));
            check_eq("ld_data",   32'(ram_dataIn), 32'h11 * 32'(j + 1));
            check_eq("ld_coregnt", 32'(core_gnt),  32'h0);
            @(posedge clk); #1;
            check_eq("ld_rvalid", 32'(core_rvalid), 32'h0);
            @(negedge clk);
            if (j == 2) begin
                ld_req = 1'b0;
            end else begin
                ld_addr = 8'd11 + 8'(j);
                ld_data = 8'h11 * 8'(j + 2);
            end
            #1;
        end
        check_eq("ldexit_gnt",   32'(core_gnt), 32'h0);
        check_eq("ldexit_ldgnt", 32'(ld_gnt),   32'h0);
        @(posedge clk); #1;
        check_eq("drain_busy", 32'(ld_busy), 32'h1);
        @(negedge clk); #1;
        check_eq("drain_gnt",   32'(core_gnt), 32'h0);
        check_eq("drain_ldgnt", 32'(ld_gnt),   32'h0);
        @(posedge clk); #1;
        check_eq("resume_busy", 32'(ld_busy), 32'h0);
        @(negedge clk); #1;
        check_eq("resume_gnt",  32'(core_gnt), 32'h2);
        check_eq("resume_addr", 32'(ram_addr), 32'd11);
        @(posedge clk); #1;
        check_eq("resume_rvalid", 32'(core_rvalid), 32'h2);
        check_eq("resume_rdata",  32'(core_rdata),  32'h22);
        @(negedge clk); #1;

        // Loader re-request during DRAIN goes straight back to LOAD
        core_req = 4'b0000;
        ld_req   = 1'b1;
        ld_addr  = 8'd20;
        ld_data  = 8'h44; #1;
        check_eq("re_pre_ldgnt", 32'(ld_gnt), 32'h0);
        @(negedge clk); #1;
        check_eq("re_ldgnt1", 32'(ld_gnt),   32'h1);
        check_eq("re_addr1",  32'(ram_addr), 32'd20);
        @(negedge clk); ld_req = 1'b0;
        @(negedge clk);
        ld_req  = 1'b1;
        ld_addr = 8'd21;
        ld_data = 8'h55; #1;
        check_eq("re_drain_ldgnt", 32'(ld_gnt), 32'h0);
        @(posedge clk); #1;
        check_eq("re_busy", 32'(ld_busy), 32'h1);
        @(negedge clk); #1;
        check_eq("re_ldgnt2", 32'(ld_gnt),     32'h1);
        check_eq("re_addr2",  32'(ram_addr),   32'd21);
        check_eq("re_data2",  32'(ram_dataIn), 32'h55);
        @(negedge clk); ld_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        core_req = 4'b0001;
        set_addr(0, 8'd20); #1;
        check_eq("re_fetch_gnt", 32'(core_gnt), 32'h1);
        @(posedge clk); #1;
        check_eq("re_fetch_rdata", 32'(core_rdata), 32'h44);
        @(negedge clk); #1;

        // Asynchronous reset in the middle of LOAD
        core_req = 4'b0000;
        ld_req   = 1'b1;
        ld_addr  = 8'd30;
        ld_data  = 8'h66;
        @(negedge clk); #1;
        check_eq("arst_pre_busy",  32'(ld_busy), 32'h1);
        check_eq("arst_pre_ldgnt", 32'(ld_gnt),  32'h1);
        #2 rstN = 1'b0; #1;
        check_eq("arst_busy",   32'(ld_busy),     32'h0);
        check_eq("arst_rvalid", 32'(core_rvalid), 32'h0);
        check_eq("arst_ldgnt",  32'(ld_gnt),      32'h0);
        check_eq("arst_wren",   32'(ram_wrEn),    32'h0);
        @(negedge clk);
        rstN     = 1'b1;
        ld_req   = 1'b0;
        core_req = 4'b0100; #1;
        check_eq("arst_run_gnt",  32'(core_gnt), 32'h4);
        check_eq("arst_run_busy", 32'(ld_busy),  32'h0);
        @(posedge clk); #1;
        check_eq("arst_run_rvalid", 32'(core_rvalid), 32'h4);
        check_eq("arst_run_rdata",  32'(core_rdata),  32'h22 ^ 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
